picomips_sw_conditioner: RTL

Input conditioning stage placed directly upstream of `picoMIPS`; it drives the CPU's `SW` bus. It synchronises and debounces the raw board switches, stretches the CPU reset request, and freezes the data byte while the CPU is polling. The `poll` bit and data byte are presented to the CPU as one registered, coherent handshake.

---
 rtl/picomips_sw_conditioner.sv | 104 ++++++++++
 1 files changed

// File: rtl/picomips_sw_conditioner.sv
// picoMIPS switch conditioner: sync, debounce,
// CPU reset stretch and poll/data handshake.
module picomips_sw_conditioner #(
  parameter int n         = 8,
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 20,
  parameter int RST_HOLD  = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [n+1:0] raw_sw,
  output logic [n+1:0] SW,
  output logic         poll_pulse
);

  localparam int RW = $clog2(RST_HOLD + 1);
  localparam logic [CNT_W-1:0] DB_MAX =
    CNT_W'(DB_CYCLES - 1);
  localparam logic [RW-1:0] HOLD = RW'(RST_HOLD);

  logic [n+1:0]     r_s1;
  logic [n+1:0]     r_s2;
  logic [n+1:0]     r_db;
  logic [CNT_W-1:0] r_cnt [n+2];
  logic [RW-1:0]    r_rcnt;
  logic             r_rst_n;
  logic             r_poll;
  logic             r_pulse;
  logic [n-1:0]     r_data;
  logic             w_rst_next;

  // two-flop synchroniser on every raw switch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= raw_sw;
      r_s2 <= r_s1;
    end
  end

  // per-bit debounce: accept after DB_CYCLES
  // consecutive disagreeing samples
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_db <= '0;
      for (int i = 0; i < n + 2; i++)
        r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < n + 2; i++) begin
        if (r_s2[i] == r_db[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DB_MAX) begin
          r_db[i]  <= r_s2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // next CPU reset level, shared by poll gating
  always_comb begin
    w_rst_next = r_rst_n;
    if (!r_db[n+1])
      w_rst_next = 1'b0;
    else if (r_rcnt == HOLD)
      w_rst_next = 1'b1;
  end

  // reset hold counter, saturating at RST_HOLD
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rcnt  <= '0;
      r_rst_n <= 1'b0;
    end else begin
      r_rst_n <= w_rst_next;
      if (!r_db[n+1])
        r_rcnt <= '0;
      else if (r_rcnt != HOLD)
        r_rcnt <= r_rcnt + RW'(1);
    end
  end

  // poll, strobe and data latch frozen while polling
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_poll  <= 1'b0;
      r_pulse <= 1'b0;
      r_data  <= '0;
    end else begin
      r_poll  <= r_db[n] & w_rst_next;
      r_pulse <= r_db[n] & ~r_poll & w_rst_next;
      if (!r_poll)
        r_data <= r_db[n-1:0];
    end
  end

  assign SW         = {r_rst_n, r_poll, r_data};
  assign poll_pulse = r_pulse;

endmodule
